db15_shift_responder: RTL

- Emulates the parallel-in/serial-out shift-register chain inside a DB15 joystick adapter. It is the responder end of the JOY_CLK / JOY_LOAD / JOY_DATA serial joystick link.
- It snapshots two 16-bit button words when the receiver asserts load. It then shifts the snapshot out one bit per receiver clock edge.
- Uses: loopback bench model for the DB15 receiver, and an on-board responder when one MiSTer drives another core's user port.
- Lives in the clk_sys domain. The receiver-driven inputs are asynchronous and are synchronised internally.

---
 rtl/db15_shift_responder_if.sv | 25 ++
 rtl/db15_shift_responder.sv | 115 +++++++++++
 2 files changed

// File: rtl/db15_shift_responder_if.sv
// DB15 serial joystick link bundle: button words, receiver-driven JOY_CLK / JOY_LOAD,
// and the responder's JOY_DATA plus status outputs.
//   master : receiver / stimulus side (drives buttons, joy_clk, joy_load)
//   slave  : responder side (drives joy_data, busy, frame_done, timeout_err, frame_count)
interface db15_shift_responder_if;
   logic [15:0] joy1_in;      // player 1 buttons, active-high, FEDCBAUDLR
   logic [15:0] joy2_in;      // player 2 buttons, same layout
   logic        joy_clk;      // serial clock from receiver, asynchronous
   logic        joy_load;     // parallel load, active-low, asynchronous
   logic        joy_data;     // serial data, active-low (pressed = 0)
   logic        busy;         // high in LOADED or SHIFTING
   logic        frame_done;   // one-cycle pulse after the last shift
   logic        timeout_err;  // one-cycle pulse when a frame is abandoned
   logic [7:0]  frame_count;  // completed frames, wrapping

   modport master (
      output joy1_in, joy2_in, joy_clk, joy_load,
      input  joy_data, busy, frame_done, timeout_err, frame_count
   );

   modport slave (
      input  joy1_in, joy2_in, joy_clk, joy_load,
      output joy_data, busy, frame_done, timeout_err, frame_count
   );
endinterface

// File: rtl/db15_shift_responder.sv
// Responder end of the DB15 JOY_CLK / JOY_LOAD / JOY_DATA serial joystick link. Emulates the
// 74HC165 parallel-in/serial-out chain: snapshots {joy2_in, joy1_in} while load is asserted,
// then presents one bit per rising joy_clk, LSB (joy1_in[0]) first.
// Ports:
//   clk   : system clock (clk_sys domain)
//   reset : asynchronous, active-high reset
//   bus   : db15_shift_responder_if.slave (buttons, joy_clk, joy_load in; joy_data and
//           status out)
module db15_shift_responder #(
   parameter int unsigned NBITS       = 32,     // bits per frame, two 16-bit words
   parameter int unsigned TIMEOUT     = 65535,  // idle clks in SHIFTING before abandoning
   parameter int unsigned SYNC_STAGES = 2       // synchroniser depth, at least 2
) (
   input logic                   clk,
   input logic                   reset,
   db15_shift_responder_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StLoaded, StShifting, StDone} state_t;

   localparam logic [5:0]  LastBit  = 6'(NBITS - 1);
   localparam logic [15:0] LastTick = 16'(TIMEOUT - 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] load_sync;
   logic                   hist_clk;
   logic                   clk_rise;
   logic                   load_act;

   state_t                 state;
   logic [NBITS-1:0]       shift_reg;
   logic [5:0]             bit_cnt;
   logic [15:0]            tcnt;
   logic                   frame_done;
   logic                   timeout_err;
   logic [7:0]             frame_count;

   // Receiver pins are asynchronous; joy_load idles high so its chain resets to 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= '0;
         load_sync <= '1;
         hist_clk  <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.joy_clk};
         load_sync <= {load_sync[SYNC_STAGES-2:0], bus.joy_load};
         hist_clk  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign clk_rise = clk_sync[SYNC_STAGES-1] & ~hist_clk;
   assign load_act = ~load_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         tcnt        <= '0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         // Load is level-sensitive and overrides everything, including a coincident clk_rise.
         if (load_act) begin
            shift_reg <= {bus.joy2_in, bus.joy1_in};
            bit_cnt   <= '0;
            tcnt      <= '0;
            state     <= StLoaded;
         end else begin
            unique case (state)
               StIdle: begin
               end
               StLoaded, StShifting: begin
                  if (clk_rise) begin
                     shift_reg <= {1'b0, shift_reg[NBITS-1:1]};
                     bit_cnt   <= bit_cnt + 6'd1;
                     tcnt      <= '0;
                     if (bit_cnt == LastBit) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        state       <= StDone;
                     end else begin
                        state <= StShifting;
                     end
                  end else if (tcnt == LastTick) begin
                     // Receiver went quiet: drop the frame and idle with joy_data released.
                     shift_reg   <= '0;
                     tcnt        <= '0;
                     timeout_err <= 1'b1;
                     state       <= StIdle;
                  end else begin
                     state <= StShifting;
                     if (tcnt != 16'hFFFF) begin
                        tcnt <= tcnt + 16'd1;
                     end
                  end
               end
               StDone: begin
               end
            endcase
         end
      end
   end

   // shift_reg is all-zero outside a frame, so the line idles released (1).
   assign bus.joy_data    = ~shift_reg[0];
   assign bus.busy        = (state == StLoaded) || (state == StShifting);
   assign bus.frame_done  = frame_done;
   assign bus.timeout_err = timeout_err;
   assign bus.frame_count = frame_count;

endmodule
